// File: rtl/aha_axi_sif_bridge_pkg.sv
// Shared burst/response encodings and the AXI next-beat address function.
// Latency: combinational helpers only.
// Backpressure: none (no state).
package aha_sif_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // A WRAP burst is only legal for 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    // Address of the beat after 'addr'; WRAP keeps the upper bits and wraps
    // the low bits modulo the burst footprint (LEN+1)<<SIZE.
    function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                              input logic [2:0]  size,
                                              input logic [7:0]  len,
                                              input logic [1:0]  burst);
        logic [31:0] step;
        logic [31:0] mask;
        step = 32'd1 << size;
        mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~mask) | ((addr + step) & mask);
            default:     next_addr = addr + step;
        endcase
    endfunction

endpackage

// File: rtl/aha_axi_sif_bridge_if.sv
// AXI4 slave port plus SIF master port of the bridge, bundled as one interface.
// Latency: wires only.
// Backpressure: carried by the AXI VALID/READY pairs; SIF has none.
interface aha_axi_sif_bridge_if #(
    parameter int ID_W       = 4,
    parameter int DATA_W     = 64,
    parameter int SIF_ADDR_W = 22
);
    logic [ID_W-1:0]       AWID;
    logic [31:0]           AWADDR;
    logic [7:0]            AWLEN;
    logic [2:0]            AWSIZE;
    logic [1:0]            AWBURST;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [DATA_W-1:0]     WDATA;
    logic [DATA_W/8-1:0]   WSTRB;
    logic                  WLAST;
    logic                  WVALID;
    logic                  WREADY;
    logic [ID_W-1:0]       BID;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;
    logic [ID_W-1:0]       ARID;
    logic [31:0]           ARADDR;
    logic [7:0]            ARLEN;
    logic [2:0]            ARSIZE;
    logic [1:0]            ARBURST;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [ID_W-1:0]       RID;
    logic [DATA_W-1:0]     RDATA;
    logic [1:0]            RRESP;
    logic                  RLAST;
    logic                  RVALID;
    logic                  RREADY;
    logic                  SIF_WR_EN;
    logic [SIF_ADDR_W-1:0] SIF_WR_ADDR;
    logic [DATA_W-1:0]     SIF_WR_DATA;
    logic [DATA_W/8-1:0]   SIF_WR_STRB;
    logic                  SIF_RD_EN;
    logic [SIF_ADDR_W-1:0] SIF_RD_ADDR;
    logic [DATA_W-1:0]     SIF_RD_DATA;
    logic                  SIF_RD_VALID;

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY,
        output SIF_WR_EN, SIF_WR_ADDR, SIF_WR_DATA, SIF_WR_STRB,
        output SIF_RD_EN, SIF_RD_ADDR,
        input  SIF_RD_DATA, SIF_RD_VALID
    );

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY,
        input  SIF_WR_EN, SIF_WR_ADDR, SIF_WR_DATA, SIF_WR_STRB,
        input  SIF_RD_EN, SIF_RD_ADDR,
        output SIF_RD_DATA, SIF_RD_VALID
    );
endinterface

// File: rtl/aha_axi_sif_bridge_rfifo.sv
// Synchronous FIFO holding read-return beats {data, last}.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: push is dropped when full unless a pop frees the slot in the same cycle.
module aha_sif_rfifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);
    assign pop_dat = mem[rd_ptr];

    // Pointers and occupancy; push and pop together leave count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage array, no reset needed: reads are qualified by empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

// File: rtl/aha_axi_sif_bridge.sv
// AXI4 slave to SIF bridge: bursts (FIXED/INCR/WRAP) become per-beat SIF accesses.
// Latency: SIF write in the W beat cycle; R beat RD_LAT+1 cycles after its SIF read.
// Backpressure: RREADY stalls via the return FIFO, reads issue only while FIFO room remains.
module aha_axi_sif_bridge #(
    parameter int ID_W       = 4,
    parameter int DATA_W     = 64,
    parameter int SIF_ADDR_W = 22,
    parameter int RD_LAT     = 1,
    parameter int RFIFO_D    = 4
) (
    input logic                CLK,
    input logic                RESET,
    aha_axi_sif_bridge_if.slave bus
);
    import aha_sif_pkg::*;

    localparam logic [2:0]  MAX_SIZE = 3'($clog2(DATA_W/8));
    localparam int          CW       = $clog2(RFIFO_D) + 1;
    localparam logic [CW:0] OCC_MAX  = (CW+1)'(RFIFO_D);

    localparam logic [1:0] W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;
    localparam logic [1:0] R_IDLE = 2'd0, R_ISSUE = 2'd1, R_DRAIN = 2'd2;

    // ---------------- write path ----------------
    logic [1:0]      wstate;
    logic [ID_W-1:0] wid;
    logic [31:0]     waddr;
    logic [7:0]      wlen, wcnt;
    logic [2:0]      wsize;
    logic [1:0]      wburst;
    logic            werr, bvalid;
    logic [1:0]      bresp;
    logic            aw_fire, w_fire, w_end, w_mis;

    assign bus.AWREADY     = !RESET && (wstate == W_IDLE);
    assign bus.WREADY      = !RESET && (wstate == W_DATA);
    assign aw_fire         = bus.AWVALID && bus.AWREADY;
    assign w_fire          = bus.WVALID && bus.WREADY;
    assign w_end           = bus.WLAST || (wcnt == wlen);
    assign w_mis           = bus.WLAST != (wcnt == wlen);
    assign bus.SIF_WR_EN   = w_fire && !werr;
    assign bus.SIF_WR_ADDR = waddr[SIF_ADDR_W-1:0];
    assign bus.SIF_WR_DATA = bus.WDATA;
    assign bus.SIF_WR_STRB = bus.WSTRB;
    assign bus.BVALID      = bvalid;
    assign bus.BRESP       = bresp;
    assign bus.BID         = wid;

    // Write FSM: latch AW, forward each W beat to SIF, then hold B until taken.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wstate <= W_IDLE;
            wid    <= '0;
            waddr  <= '0;
            wlen   <= '0;
            wcnt   <= '0;
            wsize  <= '0;
            wburst <= '0;
            werr   <= 1'b0;
            bvalid <= 1'b0;
            bresp  <= RESP_OKAY;
        end else begin
            case (wstate)
                W_IDLE: if (aw_fire) begin
                    wid    <= bus.AWID;
                    waddr  <= bus.AWADDR;
                    wlen   <= bus.AWLEN;
                    wsize  <= bus.AWSIZE;
                    wburst <= bus.AWBURST;
                    wcnt   <= '0;
                    werr   <= (bus.AWSIZE > MAX_SIZE) || (bus.AWBURST == 2'b11) ||
                              ((bus.AWBURST == BURST_WRAP) && !wrap_len_ok(bus.AWLEN));
                    wstate <= W_DATA;
                end
                W_DATA: if (w_fire) begin
                    if (w_end) begin
                        bvalid <= 1'b1;
                        bresp  <= (werr || w_mis) ? RESP_SLVERR : RESP_OKAY;
                        wstate <= W_RESP;
                    end else begin
                        waddr <= next_addr(waddr, wsize, wlen, wburst);
                        wcnt  <= wcnt + 8'd1;
                    end
                end
                W_RESP: if (bus.BREADY) begin
                    bvalid <= 1'b0;
                    wstate <= W_IDLE;
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // ---------------- read path ----------------
    logic [1:0]        rstate;
    logic [ID_W-1:0]   rid;
    logic [31:0]       raddr;
    logic [7:0]        rlen, rcnt;
    logic [2:0]        rsize;
    logic [1:0]        rburst;
    logic              rerr;
    logic [1:0]        rresp;
    logic [CW-1:0]     inflight;
    logic [RD_LAT-1:0] pipe_vld, pipe_last;
    logic [CW:0]       occ;
    logic              ar_fire, room, issue, r_last_issue;
    logic              f_push, f_pop, f_full, f_empty;
    logic [DATA_W:0]   f_push_dat, f_dat;
    logic [CW-1:0]     f_count;

    assign bus.ARREADY     = !RESET && (rstate == R_IDLE) && f_empty;
    assign ar_fire         = bus.ARVALID && bus.ARREADY;
    assign occ             = {1'b0, f_count} + {1'b0, inflight};
    assign room            = !f_full && (occ < OCC_MAX);
    assign issue           = (rstate == R_ISSUE) && room;
    assign r_last_issue    = (rcnt == rlen);
    assign bus.SIF_RD_EN   = issue && !rerr;
    assign bus.SIF_RD_ADDR = raddr[SIF_ADDR_W-1:0];

    // Errored bursts skip SIF entirely and queue zero beats directly.
    assign f_push     = rerr ? issue : (pipe_vld[RD_LAT-1] && bus.SIF_RD_VALID);
    assign f_push_dat = rerr ? {{DATA_W{1'b0}}, r_last_issue}
                             : {bus.SIF_RD_DATA, pipe_last[RD_LAT-1]};
    assign f_pop      = bus.RVALID && bus.RREADY;

    assign bus.RVALID = !RESET && !f_empty;
    assign bus.RDATA  = bus.RVALID ? f_dat[DATA_W:1] : '0;
    assign bus.RLAST  = bus.RVALID && f_dat[0];
    assign bus.RID    = rid;
    assign bus.RRESP  = rresp;

    aha_sif_rfifo #(.WIDTH(DATA_W + 1), .DEPTH(RFIFO_D)) u_rfifo (
        .clk      (CLK),
        .rst      (RESET),
        .push     (f_push),
        .push_dat (f_push_dat),
        .pop      (f_pop),
        .pop_dat  (f_dat),
        .full     (f_full),
        .empty    (f_empty),
        .count    (f_count)
    );

    // Fixed-latency tracker marking which cycle returns data and whether it is the last beat.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pipe_vld  <= '0;
            pipe_last <= '0;
            inflight  <= '0;
        end else begin
            pipe_vld[0]  <= bus.SIF_RD_EN;
            pipe_last[0] <= r_last_issue;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_last[i] <= pipe_last[i-1];
            end
            inflight <= inflight + CW'(bus.SIF_RD_EN) - CW'(pipe_vld[RD_LAT-1]);
        end
    end

    // Read FSM: latch AR, issue one read per beat while room remains, wait for last pop.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rstate <= R_IDLE;
            rid    <= '0;
            raddr  <= '0;
            rlen   <= '0;
            rcnt   <= '0;
            rsize  <= '0;
            rburst <= '0;
            rerr   <= 1'b0;
            rresp  <= RESP_OKAY;
        end else begin
            case (rstate)
                R_IDLE: if (ar_fire) begin
                    rid    <= bus.ARID;
                    raddr  <= bus.ARADDR;
                    rlen   <= bus.ARLEN;
                    rsize  <= bus.ARSIZE;
                    rburst <= bus.ARBURST;
                    rcnt   <= '0;
                    rerr   <= (bus.ARSIZE > MAX_SIZE) || (bus.ARBURST == 2'b11) ||
                              ((bus.ARBURST == BURST_WRAP) && !wrap_len_ok(bus.ARLEN));
                    rresp  <= ((bus.ARSIZE > MAX_SIZE) || (bus.ARBURST == 2'b11) ||
                              ((bus.ARBURST == BURST_WRAP) && !wrap_len_ok(bus.ARLEN)))
                              ? RESP_SLVERR : RESP_OKAY;
                    rstate <= R_ISSUE;
                end
                R_ISSUE: if (issue) begin
                    raddr <= next_addr(raddr, rsize, rlen, rburst);
                    rcnt  <= rcnt + 8'd1;
                    if (r_last_issue) rstate <= R_DRAIN;
                end
                R_DRAIN: if (f_pop && f_dat[0]) rstate <= R_IDLE;
                default: rstate <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aha_axi_sif_bridge.sv
// Directed bench for the AXI-to-SIF bridge with a 1-cycle SIF memory responder.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Logs of SIF accesses and R beats are compared to hand-computed expectations.
module tb_aha_axi_sif_bridge;
    import aha_sif_pkg::*;

    logic CLK = 1'b0;
    logic RESET;
    int   n_chk = 0;
    int   n_fail = 0;

    aha_axi_sif_bridge_if #(.ID_W(4), .DATA_W(64), .SIF_ADDR_W(22)) bus ();

    aha_axi_sif_bridge #(.ID_W(4), .DATA_W(64), .SIF_ADDR_W(22), .RD_LAT(1), .RFIFO_D(4)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    function automatic logic [63:0] rpat(input logic [21:0] a);
        return {32'hC0DE_0000, 10'd0, a};
    endfunction

    // SIF memory: data for the sampled read address one cycle later.
    always @(posedge CLK) begin
        bus.SIF_RD_VALID <= bus.SIF_RD_EN;
        bus.SIF_RD_DATA  <= rpat(bus.SIF_RD_ADDR);
    end

    logic [21:0] wq_addr[$];
    logic [63:0] wq_data[$];
    logic [7:0]  wq_strb[$];
    logic [21:0] rdq_addr[$];
    logic [63:0] rq_data[$];
    logic [1:0]  rq_resp[$];
    logic        rq_last[$];
    logic [3:0]  rq_id[$];
    int          n_issued = 0;
    int          n_popped = 0;
    int          maxout = 0;

    always @(negedge CLK) begin
        if (bus.SIF_WR_EN) begin
            wq_addr.push_back(bus.SIF_WR_ADDR);
            wq_data.push_back(bus.SIF_WR_DATA);
            wq_strb.push_back(bus.SIF_WR_STRB);
        end
        if (bus.SIF_RD_EN) begin
            rdq_addr.push_back(bus.SIF_RD_ADDR);
            n_issued++;
        end
        if (bus.RVALID && bus.RREADY) begin
            rq_data.push_back(bus.RDATA);
            rq_resp.push_back(bus.RRESP);
            rq_last.push_back(bus.RLAST);
            rq_id.push_back(bus.RID);
            n_popped++;
        end
        if (n_issued - n_popped > maxout) maxout = n_issued - n_popped;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, output logic hs);
        hs = 1'b0;
        bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len; bus.AWSIZE = size; bus.AWBURST = burst;
        bus.AWVALID = 1'b1;
        for (int c = 0; c < 50 && !hs; c++) begin
            @(negedge CLK);
            hs = bus.AWREADY;
            tick();
        end
        bus.AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] data, input logic last, output logic hs);
        hs = 1'b0;
        bus.WDATA = data; bus.WSTRB = 8'hFF; bus.WLAST = last; bus.WVALID = 1'b1;
        for (int c = 0; c < 50 && !hs; c++) begin
            @(negedge CLK);
            hs = bus.WREADY;
            tick();
        end
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;
    endtask

    // Full write: beats 0..last_at, WLAST on beat last_at, then collect B.
    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int last_at,
                             output logic ok, output logic got, output logic [1:0] resp,
                             output logic [3:0] bid);
        logic hs;
        send_aw(id, addr, len, size, burst, ok);
        for (int b = 0; b <= last_at; b++) begin
            send_w({32'h1122_3344, 24'h0, 8'(b)}, (b == last_at), hs);
            ok = ok && hs;
        end
        got = 1'b0; resp = 2'b11; bid = 4'hF;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge CLK);
            if (bus.BVALID) begin
                got = 1'b1; resp = bus.BRESP; bid = bus.BID;
            end
            tick();
        end
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, output logic hs);
        hs = 1'b0;
        bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len; bus.ARSIZE = size; bus.ARBURST = burst;
        bus.ARVALID = 1'b1;
        for (int c = 0; c < 100 && !hs; c++) begin
            @(negedge CLK);
            hs = bus.ARREADY;
            tick();
        end
        bus.ARVALID = 1'b0;
    endtask

    task automatic wait_r(input int n);
        for (int c = 0; c < 300 && rq_data.size() < n; c++) tick();
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          wb, rb, qb;
        logic        ok, got, seen;
        logic [1:0]  resp;
        logic [3:0]  bid;
        logic [21:0] ea [4];

        RESET = 1'b1;
        bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0;
        bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0;
        bus.BREADY = 1'b1; bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0;
        bus.ARBURST = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_eq("rst_ready", {61'd0, bus.AWREADY, bus.WREADY, bus.ARREADY}, 64'd0);
        check_eq("rst_valid", {62'd0, bus.BVALID, bus.RVALID}, 64'd0);
        check_eq("rst_sif_en", {62'd0, bus.SIF_WR_EN, bus.SIF_RD_EN}, 64'd0);
        check_eq("rst_ids_resps", {52'd0, bus.BID, bus.RID, bus.BRESP, bus.RRESP}, 64'd0);
        check_eq("rst_rdata", bus.RDATA, 64'd0);
        tick();
        RESET = 1'b0;
        @(negedge CLK);
        check_eq("idle_awready", 64'(bus.AWREADY), 64'd1);
        check_eq("idle_arready", 64'(bus.ARREADY), 64'd1);
        tick();

        // Single INCR write
        wb = wq_addr.size();
        axi_write(4'h3, 32'h100, 8'd0, 3'd3, BURST_INCR, 0, ok, got, resp, bid);
        check_eq("t1_hs", 64'(ok), 64'd1);
        check_eq("t1_bseen", 64'(got), 64'd1);
        check_eq("t1_bresp", 64'(resp), 64'(RESP_OKAY));
        check_eq("t1_bid", 64'(bid), 64'h3);
        check_eq("t1_nwr", 64'(wq_addr.size() - wb), 64'd1);
        if (wq_addr.size() > wb) begin
            check_eq("t1_addr", 64'(wq_addr[wb]), 64'h100);
            check_eq("t1_data", wq_data[wb], 64'h1122_3344_0000_0000);
            check_eq("t1_strb", 64'(wq_strb[wb]), 64'hFF);
        end

        // WRAP read, 4 beats from 0x118
        ea[0] = 22'h118; ea[1] = 22'h100; ea[2] = 22'h108; ea[3] = 22'h110;
        rb = rdq_addr.size(); qb = rq_data.size();
        axi_read(4'h5, 32'h118, 8'd3, 3'd3, BURST_WRAP, ok);
        check_eq("t2_hs", 64'(ok), 64'd1);
        wait_r(qb + 4);
        check_eq("t2_nrd", 64'(rdq_addr.size() - rb), 64'd4);
        check_eq("t2_nbeat", 64'(rq_data.size() - qb), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (rdq_addr.size() > rb + i) check_eq($sformatf("t2_addr%0d", i), 64'(rdq_addr[rb+i]), 64'(ea[i]));
            if (rq_data.size() > qb + i) begin
                check_eq($sformatf("t2_data%0d", i), rq_data[qb+i], rpat(ea[i]));
                check_eq($sformatf("t2_last%0d", i), 64'(rq_last[qb+i]), 64'(i == 3));
                check_eq($sformatf("t2_idresp%0d", i), {58'd0, rq_id[qb+i], rq_resp[qb+i]}, {58'd0, 4'h5, RESP_OKAY});
            end
        end

        // INCR 16-beat read with RREADY stalled for 20 cycles
        bus.RREADY = 1'b0;
        rb = rdq_addr.size(); qb = rq_data.size();
        axi_read(4'h9, 32'h200, 8'd15, 3'd3, BURST_INCR, ok);
        check_eq("t3_hs", 64'(ok), 64'd1);
        repeat (20) tick();
        check_eq("t3_nrd_stalled", 64'(rdq_addr.size() - rb), 64'd4);
        check_eq("t3_nbeat_stalled", 64'(rq_data.size() - qb), 64'd0);
        check_eq("t3_maxout_stalled", 64'(maxout), 64'd4);
        bus.RREADY = 1'b1;
        wait_r(qb + 16);
        check_eq("t3_nrd", 64'(rdq_addr.size() - rb), 64'd16);
        check_eq("t3_nbeat", 64'(rq_data.size() - qb), 64'd16);
        for (int i = 0; i < 16; i++) begin
            if (rdq_addr.size() > rb + i)
                check_eq($sformatf("t3_addr%0d", i), 64'(rdq_addr[rb+i]), 64'h200 + 64'(8 * i));
            if (rq_data.size() > qb + i) begin
                check_eq($sformatf("t3_data%0d", i), rq_data[qb+i], rpat(22'(32'h200 + 8 * i)));
                check_eq($sformatf("t3_last%0d", i), 64'(rq_last[qb+i]), 64'(i == 15));
            end
        end
        check_eq("t3_maxout", 64'(maxout), 64'd4);

        // LEN=3 write with WLAST on the 2nd beat
        wb = wq_addr.size();
        axi_write(4'h2, 32'h300, 8'd3, 3'd3, BURST_INCR, 1, ok, got, resp, bid);
        check_eq("t4_hs", 64'(ok), 64'd1);
        check_eq("t4_bseen", 64'(got), 64'd1);
        check_eq("t4_bresp", 64'(resp), 64'(RESP_SLVERR));
        check_eq("t4_nwr", 64'(wq_addr.size() - wb), 64'd2);
        if (wq_addr.size() > wb + 1) check_eq("t4_addr1", 64'(wq_addr[wb+1]), 64'h308);

        // Oversized read: no SIF access, zero data with SLVERR
        rb = rdq_addr.size(); qb = rq_data.size();
        axi_read(4'hA, 32'h700, 8'd1, 3'd4, BURST_INCR, ok);
        check_eq("t5_hs", 64'(ok), 64'd1);
        wait_r(qb + 2);
        check_eq("t5_nrd", 64'(rdq_addr.size() - rb), 64'd0);
        check_eq("t5_nbeat", 64'(rq_data.size() - qb), 64'd2);
        for (int i = 0; i < 2; i++) begin
            if (rq_data.size() > qb + i) begin
                check_eq($sformatf("t5_data%0d", i), rq_data[qb+i], 64'd0);
                check_eq($sformatf("t5_resp%0d", i), 64'(rq_resp[qb+i]), 64'(RESP_SLVERR));
                check_eq($sformatf("t5_last%0d", i), 64'(rq_last[qb+i]), 64'(i == 1));
            end
        end

        // FIXED read: address held for all 3 beats
        rb = rdq_addr.size(); qb = rq_data.size();
        axi_read(4'h1, 32'h500, 8'd2, 3'd3, BURST_FIXED, ok);
        wait_r(qb + 3);
        check_eq("t7_nrd", 64'(rdq_addr.size() - rb), 64'd3);
        for (int i = 0; i < 3; i++) begin
            if (rdq_addr.size() > rb + i) check_eq($sformatf("t7_addr%0d", i), 64'(rdq_addr[rb+i]), 64'h500);
            if (rq_data.size() > qb + i) check_eq($sformatf("t7_last%0d", i), 64'(rq_last[qb+i]), 64'(i == 2));
        end

        // Oversized write: data consumed, no SIF write, SLVERR
        wb = wq_addr.size();
        axi_write(4'h4, 32'h800, 8'd0, 3'd4, BURST_INCR, 0, ok, got, resp, bid);
        check_eq("t8_bresp", 64'(resp), 64'(RESP_SLVERR));
        check_eq("t8_nwr", 64'(wq_addr.size() - wb), 64'd0);

        // Reset in the middle of a LEN=7 write, then a clean single write
        wb = wq_addr.size();
        send_aw(4'h6, 32'h600, 8'd7, 3'd3, BURST_INCR, ok);
        for (int b = 0; b < 3; b++) send_w(64'(b), 1'b0, got);
        check_eq("t6_nwr_pre", 64'(wq_addr.size() - wb), 64'd3);
        seen = 1'b0;
        RESET = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            if (bus.BVALID) seen = 1'b1;
            tick();
        end
        RESET = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            if (bus.BVALID) seen = 1'b1;
            tick();
        end
        check_eq("t6_no_bvalid", 64'(seen), 64'd0);
        wb = wq_addr.size();
        axi_write(4'h7, 32'h400, 8'd0, 3'd3, BURST_INCR, 0, ok, got, resp, bid);
        check_eq("t6_bseen", 64'(got), 64'd1);
        check_eq("t6_bresp", 64'(resp), 64'(RESP_OKAY));
        check_eq("t6_bid", 64'(bid), 64'h7);
        check_eq("t6_nwr", 64'(wq_addr.size() - wb), 64'd1);
        if (wq_addr.size() > wb) check_eq("t6_addr", 64'(wq_addr[wb]), 64'h400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
